lru_matrix_arb_lock: RTL and testbench

- Parametrised matrix-based least-recently-used (LRU) arbiter; the next-generation arbiter for shared resources (buses, memory ports, shared FIFOs).
- Adds registered, one-hot grant with downstream acknowledge.
- Adds multi-cycle grant lock for packet transfers.
- Adds back-to-back re-arbitration with no idle bubble.
- Adds a runtime fixed-priority mode.

---
 rtl/lru_matrix_arb_lock.sv | 130 +++++++++++++
 tb/tb_lru_matrix_arb_lock.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lru_matrix_arb_lock.sv
// Matrix-based LRU arbiter with a registered one-hot grant, multi-beat grant lock,
// back-to-back re-arbitration on release, and a runtime fixed-priority override.
module lru_matrix_arb_lock #(
  parameter int N       = 4,
  parameter bit LOCK_EN = 1'b1,
  localparam int IDXW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            last,
  input  logic            ack,
  input  logic            fixed_pri,
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [N-1:0]    gnt_reg, gnt_next;
  logic [IDXW-1:0] idx_reg, idx_next;
  logic [N-1:0]    m_reg [N];
  logic [N-1:0]    m_arb [N];
  logic [N-1:0]    beats [N];
  logic [N-1:0]    win_lru, win_fix, win;
  logic [IDXW-1:0] win_idx;
  logic            release_beat;

  assign release_beat = (state_reg == GRANT) && ack && (last || !LOCK_EN);

  // Order used for arbitration: on release the served index drops to the bottom first.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      m_arb[i] = m_reg[i];
    end
    if (release_beat && !fixed_pri) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i != j) begin
            if (i == int'(idx_reg)) begin
              m_arb[i][j] = 1'b0;
            end else if (j == int'(idx_reg)) begin
              m_arb[i][j] = 1'b1;
            end
          end
        end
      end
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        if (gi == gj) begin : g_diag
          assign beats[gi][gj] = 1'b1;
        end else begin : g_off
          assign beats[gi][gj] = !req[gj] || m_arb[gi][gj];
        end
      end
      assign win_lru[gi] = req[gi] && (&beats[gi]);
    end
  endgenerate

  assign win_fix = req & (-req);
  assign win     = fixed_pri ? win_fix : win_lru;

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) begin
        win_idx = IDXW'(i);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (|req) begin
          gnt_next   = win;
          idx_next   = win_idx;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (release_beat) begin
          if (|req) begin
            gnt_next = win;
            idx_next = win_idx;
          end else begin
            gnt_next   = '0;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      idx_reg   <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          m_reg[i][j] <= (i < j);
        end
      end
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      idx_reg   <= idx_next;
      for (int i = 0; i < N; i++) begin
        m_reg[i] <= m_arb[i];
      end
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_valid = |gnt_reg;
  assign gnt_idx   = idx_reg;

endmodule

// File: tb/tb_lru_matrix_arb_lock.sv
// Bench for lru_matrix_arb_lock: two instances (lock on / lock off) checked against an
// age-list reference model, with directed scenarios followed by random traffic.
module tb_lru_matrix_arb_lock;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       last = 1'b0;
  logic       ack = 1'b0;
  logic       fixed_pri = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt0, gnt1;
  logic       v0, v1;
  logic [1:0] i0, i1;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference: ord[u][0] is the least recently served requester.
  int ord [2][N];
  bit mv [2];
  int midx [2];

  always #5 clk = ~clk;

  lru_matrix_arb_lock #(.N(N), .LOCK_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .req(req), .last(last), .ack(ack), .fixed_pri(fixed_pri),
    .gnt(gnt0), .gnt_valid(v0), .gnt_idx(i0)
  );

  lru_matrix_arb_lock #(.N(N), .LOCK_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .req(req), .last(last), .ack(ack), .fixed_pri(fixed_pri),
    .gnt(gnt1), .gnt_valid(v1), .gnt_idx(i1)
  );

  function automatic int pick(int u);
    if (fixed_pri) begin
      for (int k = 0; k < N; k++) if (req[k]) return k;
    end else begin
      for (int p = 0; p < N; p++) if (req[ord[u][p]]) return ord[u][p];
    end
    return 0;
  endfunction

  task automatic demote(int u, int k);
    int p = 0;
    while (ord[u][p] != k) p++;
    for (int q = p; q < N - 1; q++) ord[u][q] = ord[u][q + 1];
    ord[u][N - 1] = k;
  endtask

  task automatic model_step(int u, bit le);
    if (rst) begin
      mv[u] = 1'b0;
      midx[u] = 0;
      for (int k = 0; k < N; k++) ord[u][k] = k;
    end else if (!mv[u]) begin
      if (req != 4'b0) begin
        midx[u] = pick(u);
        mv[u] = 1'b1;
      end
    end else if (ack && (last || !le)) begin
      if (!fixed_pri) demote(u, midx[u]);
      if (req != 4'b0) midx[u] = pick(u);
      else mv[u] = 1'b0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_inst(int u, logic [3:0] g, logic v, logic [1:0] ix);
    logic [3:0] eg;
    eg = mv[u] ? (4'b0001 << midx[u]) : 4'b0000;
    chk($sformatf("gnt%0d", u), 32'(g), 32'(eg));
    chk($sformatf("valid%0d", u), 32'(v), 32'(mv[u]));
    chk($sformatf("idx%0d", u), 32'(ix), 32'(midx[u]));
    chk($sformatf("onehot%0d", u), 32'($onehot0(g)), 32'd1);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    #1;
    cyc++;
    $display("cyc %0d rst=%b req=%b ack=%b last=%b fp=%b gnt0=%b gnt1=%b",
             cyc, rst, req, ack, last, fixed_pri, gnt0, gnt1);
    check_inst(0, gnt0, v0, i0);
    check_inst(1, gnt1, v1, i1);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0; ack = 1'b0; last = 1'b0; fixed_pri = 1'b0;
    cycle();
    chk("rst_gnt", 32'(gnt0), 32'd0);
    chk("rst_idx", 32'(i0), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] s1 [5];
    logic [3:0] s2 [6];
    s1 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    s2 = '{4'h2, 4'h8, 4'h1, 4'h4, 4'h2, 4'h8};

    // Round robin under full load, no bubbles.
    do_reset();
    req = 4'b1111; ack = 1'b1; last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t1_seq", 32'(gnt0), 32'(s1[k]));
    end

    // Non-requesting indices keep their age.
    do_reset();
    req = 4'b1010; ack = 1'b1; last = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) req = 4'b1111;
      cycle();
      chk("t2_seq", 32'(gnt0), 32'(s2[k]));
    end

    // Lock held across last=0 beats; lock-off instance rotates instead.
    do_reset();
    req = 4'b0011;
    cycle();
    chk("t3_first", 32'(gnt0), 32'h1);
    ack = 1'b1; last = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t3_lock", 32'(gnt0), 32'h1);
    end
    last = 1'b1;
    cycle();
    chk("t3_release", 32'(gnt0), 32'h2);

    // Fixed priority freezes the matrix.
    do_reset();
    fixed_pri = 1'b1; req = 4'b1100; ack = 1'b1; last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("t4_fixed", 32'(gnt0), 32'h4);
    end
    req = 4'b0000;
    cycle();
    chk("t4_idle", 32'(v0), 32'd0);
    fixed_pri = 1'b0; req = 4'b1100;
    cycle();
    chk("t4_lru_a", 32'(gnt0), 32'h4);
    cycle();
    chk("t4_lru_b", 32'(gnt0), 32'h8);

    // Single grant then return to IDLE; lock-off instance ignores last.
    do_reset();
    req = 4'b0100; ack = 1'b1; last = 1'b1;
    cycle();
    chk("t5_gnt", 32'(gnt0), 32'h4);
    req = 4'b0000;
    cycle();
    chk("t5_gnt_off", 32'(gnt0), 32'h0);
    chk("t5_valid_off", 32'(v0), 32'd0);
    do_reset();
    req = 4'b1111; ack = 1'b1; last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t5_nolock_seq", 32'(gnt1), 32'(s1[k]));
    end

    // Reset mid-lock restores the initial order.
    do_reset();
    req = 4'b0011; ack = 1'b1; last = 1'b1;
    cycle();
    cycle();
    chk("t6_pre", 32'(gnt0), 32'h2);
    last = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    chk("t6_rst", 32'(gnt0), 32'h0);
    rst = 1'b0;
    cycle();
    chk("t6_after", 32'(gnt0), 32'h1);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom_range(0, 49) == 0);
      req       = 4'($urandom);
      ack       = 1'($urandom);
      last      = 1'($urandom);
      fixed_pri = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
